// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: shares one floating-point adder between two requesters.
// Arbitration is round-robin by default. Each accepted add pushes its
// requester ID into a tag FIFO; adder results (assumed in order) pop the FIFO
// and are steered to the matching result port one cycle later.
// Optional macro FP_ARB_FIXED_PRIO_EN: requester 0 always wins contention and
// the last-granted register is removed.
module fp_add_arbiter #(
   parameter int C_DATA_WIDTH = 32,
   parameter int C_TAG_DEPTH  = 16,
   parameter int C_PTR_WIDTH  = 4
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    req0_valid,
   input  logic                    req1_valid,
   output logic                    req0_ready,
   output logic                    req1_ready,
   input  logic [C_DATA_WIDTH-1:0] req0_a,
   input  logic [C_DATA_WIDTH-1:0] req0_b,
   input  logic [C_DATA_WIDTH-1:0] req1_a,
   input  logic [C_DATA_WIDTH-1:0] req1_b,
   output logic                    res0_valid,
   output logic                    res1_valid,
   output logic [C_DATA_WIDTH-1:0] res0_data,
   output logic [C_DATA_WIDTH-1:0] res1_data,
   output logic [C_DATA_WIDTH-1:0] add_a,
   output logic [C_DATA_WIDTH-1:0] add_b,
   output logic                    add_valid,
   input  logic [C_DATA_WIDTH-1:0] add_result,
   input  logic                    add_rdy,
   output logic [C_PTR_WIDTH:0]    outstanding,
   output logic                    err_underflow
);

   localparam logic [C_PTR_WIDTH:0] DEPTH = (C_PTR_WIDTH+1)'(C_TAG_DEPTH);

   logic                    grant;          // requester index offered this cycle
   logic [1:0]              accept;
   logic                    push;
   logic                    pop;
   logic                    underflow;
   logic                    not_full;
   logic                    pop_tag;
   logic [C_DATA_WIDTH-1:0] sel_a;
   logic [C_DATA_WIDTH-1:0] sel_b;

   logic [C_DATA_WIDTH-1:0] add_a_reg;
   logic [C_DATA_WIDTH-1:0] add_b_reg;
   logic                    add_valid_reg;
   logic [C_PTR_WIDTH:0]    outstanding_reg;
   logic [C_PTR_WIDTH:0]    outstanding_next;
   logic [C_PTR_WIDTH-1:0]  wr_ptr_reg;
   logic [C_PTR_WIDTH-1:0]  rd_ptr_reg;
   logic                    err_underflow_reg;
   logic                    tag_mem [C_TAG_DEPTH];

`ifndef FP_ARB_FIXED_PRIO_EN
   logic                    last_grant_reg;
`endif

   // Full is judged on the registered count, so a pop in the full cycle only
   // frees a slot from the following cycle on.
   assign not_full  = (outstanding_reg < DEPTH);
   assign pop       = add_rdy && (outstanding_reg != '0);
   assign underflow = add_rdy && (outstanding_reg == '0);
   assign pop_tag   = tag_mem[rd_ptr_reg];

   // Pick which requester is offered the slot this cycle.
   always_comb begin
      grant = 1'b0;
      if (req0_valid && req1_valid) begin
`ifdef FP_ARB_FIXED_PRIO_EN
         grant = 1'b0;
`else
         grant = ~last_grant_reg;
`endif
      end else if (req1_valid) begin
         grant = 1'b1;
      end
   end

   assign accept[0]  = req0_valid && !grant && not_full;
   assign accept[1]  = req1_valid &&  grant && not_full;
   assign push       = |accept;
   assign req0_ready = accept[0];
   assign req1_ready = accept[1];
   assign sel_a      = accept[1] ? req1_a : req0_a;
   assign sel_b      = accept[1] ? req1_b : req0_b;

   // In-flight count: push and pop in the same cycle cancel out.
   always_comb begin
      outstanding_next = outstanding_reg;
      case ({push, pop})
         2'b10:   outstanding_next = outstanding_reg + 1'b1;
         2'b01:   outstanding_next = outstanding_reg - 1'b1;
         default: outstanding_next = outstanding_reg;
      endcase
   end

   // Adder launch register, FIFO pointers, count and sticky underflow flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         add_valid_reg     <= 1'b0;
         add_a_reg         <= '0;
         add_b_reg         <= '0;
         outstanding_reg   <= '0;
         wr_ptr_reg        <= '0;
         rd_ptr_reg        <= '0;
         err_underflow_reg <= 1'b0;
      end else begin
         add_valid_reg   <= push;
         outstanding_reg <= outstanding_next;
         if (push) begin
            add_a_reg  <= sel_a;
            add_b_reg  <= sel_b;
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         if (underflow) begin
            err_underflow_reg <= 1'b1;
         end
      end
   end

`ifndef FP_ARB_FIXED_PRIO_EN
   // Remember who was accepted last; starts at 1 so requester 0 wins first.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_grant_reg <= 1'b1;
      end else if (push) begin
         last_grant_reg <= accept[1];
      end
   end
`endif

   // Tag storage holds the requester ID of every in-flight add.
   always_ff @(posedge clk) begin
      if (push) begin
         tag_mem[wr_ptr_reg] <= accept[1];
      end
   end

   // One result channel per requester, strobed when the popped tag matches.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : res_ch
         logic                    valid_reg;
         logic [C_DATA_WIDTH-1:0] data_reg;

         // Register the adder result into this channel on a matching pop.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               valid_reg <= 1'b0;
               data_reg  <= '0;
            end else begin
               valid_reg <= pop && (pop_tag == 1'(gi));
               if (pop && (pop_tag == 1'(gi))) begin
                  data_reg <= add_result;
               end
            end
         end
      end
   endgenerate

   assign res0_valid    = res_ch[0].valid_reg;
   assign res0_data     = res_ch[0].data_reg;
   assign res1_valid    = res_ch[1].valid_reg;
   assign res1_data     = res_ch[1].data_reg;
   assign add_a         = add_a_reg;
   assign add_b         = add_b_reg;
   assign add_valid     = add_valid_reg;
   assign outstanding   = outstanding_reg;
   assign err_underflow = err_underflow_reg;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Testbench for fp_add_arbiter: scenario tasks drive requesters and a fake
// adder; expected result tags/data go into a scoreboard that a monitor drains
// whenever a result strobe appears.
module tb_fp_add_arbiter;

   localparam int DW = 32;
   localparam int PW = 4;

   logic          clk = 1'b0;
   logic          reset_n = 1'b1;
   logic          req0_valid = 1'b0, req1_valid = 1'b0;
   logic          req0_ready, req1_ready;
   logic [DW-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic          res0_valid, res1_valid;
   logic [DW-1:0] res0_data, res1_data;
   logic [DW-1:0] add_a, add_b;
   logic          add_valid;
   logic [DW-1:0] add_result = '0;
   logic          add_rdy = 1'b0;
   logic [PW:0]   outstanding;
   logic          err_underflow;

   fp_add_arbiter dut (
      .clk(clk), .reset_n(reset_n),
      .req0_valid(req0_valid), .req1_valid(req1_valid),
      .req0_ready(req0_ready), .req1_ready(req1_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
      .res0_valid(res0_valid), .res1_valid(res1_valid),
      .res0_data(res0_data), .res1_data(res1_data),
      .add_a(add_a), .add_b(add_b), .add_valid(add_valid),
      .add_result(add_result), .add_rdy(add_rdy),
      .outstanding(outstanding), .err_underflow(err_underflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          tag;
      logic [DW-1:0] data;
   } sb_t;

   int            vectors = 0;
   int            miscompares = 0;
   sb_t           sb_q[$];
   bit            tag_q[$];
   sb_t           mon_e;
   logic          pend_av = 1'b0, now_av = 1'b0;
   logic [DW-1:0] pend_aa = '0, pend_ab = '0, now_aa = '0, now_ab = '0;
   int            now_out = 0;
   bit            exp_err = 1'b0;
   int            op_cnt = 0;

   // One bench cycle: drive inputs at negedge and advance the reference model.
   // now_* hold what the DUT registers must show at this negedge.
   task automatic drive(input bit v0, input bit v1, input int acc,
                        input bit rdy, input logic [DW-1:0] res);
      sb_t e;
      @(negedge clk);
      now_av  = pend_av;
      now_aa  = pend_aa;
      now_ab  = pend_ab;
      now_out = tag_q.size();
      op_cnt++;
      req0_valid = v0;
      req1_valid = v1;
      req0_a = {16'hA000, 16'(op_cnt)};
      req0_b = {16'hB000, 16'(op_cnt)};
      req1_a = {16'hC000, 16'(op_cnt)};
      req1_b = {16'hD000, 16'(op_cnt)};
      add_rdy    = rdy;
      add_result = res;
      if (rdy) begin
         if (tag_q.size() == 0) begin
            exp_err = 1'b1;
         end else begin
            e.tag  = tag_q.pop_front();
            e.data = res;
            sb_q.push_back(e);
         end
      end
      pend_av = (acc >= 0);
      if (acc == 0) begin
         pend_aa = req0_a; pend_ab = req0_b; tag_q.push_back(1'b0);
      end else if (acc == 1) begin
         pend_aa = req1_a; pend_ab = req1_b; tag_q.push_back(1'b1);
      end
   endtask

   // Result monitor: every strobe must match the scoreboard head.
   always @(negedge clk) begin
      if (reset_n && (res0_valid || res1_valid)) begin
         vectors++;
         if (res0_valid && res1_valid) begin
            miscompares++;
            $display("FAIL res_both got res0_valid=1 res1_valid=1 exp one strobe");
         end else if (sb_q.size() == 0) begin
            miscompares++;
            $display("FAIL res_unexpected got strobe res1_valid=%0b exp none", res1_valid);
         end else begin
            mon_e = sb_q.pop_front();
            if (res1_valid !== mon_e.tag ||
                (res1_valid ? res1_data : res0_data) !== mon_e.data) begin
               miscompares++;
               $display("FAIL res_route got tag=%0b data=%08h exp tag=%0b data=%08h",
                        res1_valid, (res1_valid ? res1_data : res0_data), mon_e.tag, mon_e.data);
            end else begin
               $display("result tag=%0b data=%08h ok", mon_e.tag, mon_e.data);
            end
         end
      end
   end

   task automatic test_reset;
      @(negedge clk);
      reset_n = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0; add_rdy = 1'b0;
      tag_q.delete(); sb_q.delete();
      pend_av = 1'b0; pend_aa = '0; pend_ab = '0; exp_err = 1'b0;
      #1;
      vectors++; if (add_valid !== 1'b0) begin miscompares++; $display("FAIL rst_add_valid got=%0b exp=0", add_valid); end
      vectors++; if (add_a !== '0) begin miscompares++; $display("FAIL rst_add_a got=%08h exp=0", add_a); end
      vectors++; if (add_b !== '0) begin miscompares++; $display("FAIL rst_add_b got=%08h exp=0", add_b); end
      vectors++; if (res0_valid !== 1'b0 || res1_valid !== 1'b0) begin miscompares++; $display("FAIL rst_res_valid got=%0b%0b exp=00", res1_valid, res0_valid); end
      vectors++; if (res0_data !== '0 || res1_data !== '0) begin miscompares++; $display("FAIL rst_res_data got=%08h/%08h exp=0", res0_data, res1_data); end
      vectors++; if (outstanding !== '0) begin miscompares++; $display("FAIL rst_outstanding got=%0d exp=0", outstanding); end
      vectors++; if (err_underflow !== 1'b0) begin miscompares++; $display("FAIL rst_err got=%0b exp=0", err_underflow); end
      $display("reset applied, outputs checked");
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_round_robin;
      int exp_acc[4];
`ifdef FP_ARB_FIXED_PRIO_EN
      exp_acc = '{0, 0, 0, 0};
`else
      exp_acc = '{0, 1, 0, 1};
`endif
      for (int i = 0; i < 5; i++) begin
         drive(i < 4, i < 4, (i < 4) ? exp_acc[i] : -1, 1'b0, '0);
         #1;
         vectors++; if (add_valid !== now_av) begin miscompares++; $display("FAIL rr_add_valid step=%0d got=%0b exp=%0b", i, add_valid, now_av); end
         if (now_av) begin
            vectors++; if (add_a !== now_aa || add_b !== now_ab) begin miscompares++; $display("FAIL rr_operands step=%0d got=%08h/%08h exp=%08h/%08h", i, add_a, add_b, now_aa, now_ab); end
         end
         if (i < 4) begin
            vectors++;
            if (req0_ready !== (exp_acc[i] == 0) || req1_ready !== (exp_acc[i] == 1)) begin
               miscompares++; $display("FAIL rr_grant step=%0d got=%0b%0b exp accept %0d", i, req1_ready, req0_ready, exp_acc[i]);
            end else $display("contention step %0d accepted req%0d", i, exp_acc[i]);
         end
      end
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b0, -1, 1'b1, 32'h1111_0000 + 32'(i));
         #1;
         vectors++; if (outstanding !== 5'(now_out)) begin miscompares++; $display("FAIL rr_drain_out got=%0d exp=%0d", outstanding, now_out); end
      end
      repeat (2) drive(1'b0, 1'b0, -1, 1'b0, '0);
   endtask

   task automatic test_rr_history;
`ifdef FP_ARB_FIXED_PRIO_EN
      int second = 0;
`else
      int second = 1;
`endif
      drive(1'b0, 1'b1, 1, 1'b0, '0);
      #1; vectors++; if (req1_ready !== 1'b1) begin miscompares++; $display("FAIL hist_solo got=%0b exp=1", req1_ready); end
      drive(1'b0, 1'b0, -1, 1'b0, '0);
      drive(1'b1, 1'b1, 0, 1'b0, '0);
      #1; vectors++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin miscompares++; $display("FAIL hist_first got=%0b%0b exp=01", req1_ready, req0_ready); end
      drive(1'b1, 1'b1, second, 1'b0, '0);
      #1; vectors++; if (req1_ready !== (second == 1) || req0_ready !== (second == 0)) begin miscompares++; $display("FAIL hist_second got=%0b%0b exp accept %0d", req1_ready, req0_ready, second); end
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, -1, 1'b1, 32'h5555_0000 + 32'(i));
      repeat (2) drive(1'b0, 1'b0, -1, 1'b0, '0);
      $display("grant history checked");
   endtask

   task automatic test_single_result;
      drive(1'b1, 1'b0, 0, 1'b0, '0);
      req0_a = 32'h3F80_0000; req0_b = 32'h4000_0000;
      pend_aa = 32'h3F80_0000; pend_ab = 32'h4000_0000;
      #1; vectors++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin miscompares++; $display("FAIL single_accept got=%0b%0b exp=01", req1_ready, req0_ready); end
      drive(1'b0, 1'b0, -1, 1'b0, '0);
      #1; vectors++; if (add_valid !== 1'b1 || add_a !== 32'h3F80_0000 || add_b !== 32'h4000_0000) begin miscompares++; $display("FAIL single_launch got v=%0b %08h+%08h exp v=1 3f800000+40000000", add_valid, add_a, add_b); end
      drive(1'b0, 1'b0, -1, 1'b0, '0);
      #1; vectors++; if (add_valid !== 1'b0 || add_a !== 32'h3F80_0000) begin miscompares++; $display("FAIL single_hold got v=%0b a=%08h exp v=0 a=3f800000", add_valid, add_a); end
      drive(1'b0, 1'b0, -1, 1'b1, 32'h4040_0000);
      drive(1'b0, 1'b0, -1, 1'b0, '0);
      #1; vectors++; if (res0_valid !== 1'b1 || res1_valid !== 1'b0 || res0_data !== 32'h4040_0000) begin miscompares++; $display("FAIL single_result got v=%0b%0b d=%08h exp v=01 d=40400000", res1_valid, res0_valid, res0_data); end
      drive(1'b0, 1'b0, -1, 1'b0, '0);
      #1; vectors++; if (res0_valid !== 1'b0) begin miscompares++; $display("FAIL single_pulse got=%0b exp=0", res0_valid); end
   endtask

   task automatic test_full;
      for (int i = 0; i < 16; i++) begin
         drive(1'b0, 1'b1, 1, 1'b0, '0);
         #1; vectors++; if (req1_ready !== 1'b1) begin miscompares++; $display("FAIL full_fill step=%0d got=%0b exp=1", i, req1_ready); end
      end
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 1'b1, -1, 1'b0, '0);
         #1; vectors++; if (req1_ready !== 1'b0 || outstanding !== 5'd16) begin miscompares++; $display("FAIL full_block got rdy=%0b out=%0d exp rdy=0 out=16", req1_ready, outstanding); end
      end
      drive(1'b0, 1'b1, -1, 1'b1, 32'h2222_0000);
      #1; vectors++; if (req1_ready !== 1'b0) begin miscompares++; $display("FAIL full_same_cycle got=%0b exp=0", req1_ready); end
      drive(1'b0, 1'b1, 1, 1'b0, '0);
      #1; vectors++; if (req1_ready !== 1'b1 || outstanding !== 5'd15) begin miscompares++; $display("FAIL full_reopen got rdy=%0b out=%0d exp rdy=1 out=15", req1_ready, outstanding); end
      $display("tag FIFO filled and reopened");
      for (int i = 0; i < 16; i++) drive(1'b0, 1'b0, -1, 1'b1, 32'h3333_0000 + 32'(i));
      repeat (2) drive(1'b0, 1'b0, -1, 1'b0, '0);
      #1; vectors++; if (outstanding !== '0) begin miscompares++; $display("FAIL full_drained got=%0d exp=0", outstanding); end
   endtask

   task automatic test_simultaneous;
      for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 0, 1'b0, '0);
      drive(1'b0, 1'b1, 1, 1'b1, 32'h4444_0005);
      #1; vectors++; if (req1_ready !== 1'b1 || outstanding !== 5'd5) begin miscompares++; $display("FAIL simul_pre got rdy=%0b out=%0d exp rdy=1 out=5", req1_ready, outstanding); end
      drive(1'b0, 1'b0, -1, 1'b0, '0);
      #1; vectors++; if (outstanding !== 5'd5) begin miscompares++; $display("FAIL simul_post got=%0d exp=5", outstanding); end
      for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, -1, 1'b1, 32'h6666_0000 + 32'(i));
      repeat (2) drive(1'b0, 1'b0, -1, 1'b0, '0);
      $display("same-cycle push/pop checked");
   endtask

   task automatic test_underflow;
      drive(1'b0, 1'b0, -1, 1'b1, 32'hDEAD_BEEF);
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b0, -1, 1'b0, '0);
         #1; vectors++;
         if (err_underflow !== exp_err || outstanding !== '0 || res0_valid !== 1'b0 || res1_valid !== 1'b0) begin
            miscompares++; $display("FAIL underflow step=%0d got err=%0b out=%0d res=%0b%0b exp err=%0b out=0 res=00", i, err_underflow, outstanding, res1_valid, res0_valid, exp_err);
         end
      end
      $display("underflow flag sticky");
      test_reset;
   endtask

   task automatic test_reset_midflight;
      drive(1'b1, 1'b0, 0, 1'b0, '0);
      drive(1'b1, 1'b0, 0, 1'b0, '0);
      test_reset;
      drive(1'b0, 1'b0, -1, 1'b1, 32'h7777_0000);
      drive(1'b0, 1'b0, -1, 1'b0, '0);
      #1; vectors++; if (err_underflow !== 1'b1 || outstanding !== '0) begin miscompares++; $display("FAIL midflight got err=%0b out=%0d exp err=1 out=0", err_underflow, outstanding); end
      $display("in-flight tags discarded by reset");
      test_reset;
   endtask

   initial begin
      test_reset;
      test_round_robin;
      test_rr_history;
      test_single_result;
      test_full;
      test_simultaneous;
      test_underflow;
      test_reset_midflight;
      repeat (2) @(negedge clk);
      vectors++; if (sb_q.size() != 0) begin miscompares++; $display("FAIL sb_leftover got=%0d pending exp=0", sb_q.size()); end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
